// File: rtl/pll_lock_reset_sequencer.sv
// Turns the asynchronous PLL LOCK into a synchronously released reset plus a ready flag.
// Optional PLL re-reset on lock timeout is compiled in with `define PLL_LOCK_TIMEOUT_EN.
module pll_lock_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES     = 65536,
  parameter int unsigned PLL_RST_CYCLES     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       rst_out,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic       pll_rst
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxCycles =
      max2(max2(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES), max2(TIMEOUT_CYCLES, PLL_RST_CYCLES));
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  typedef enum logic [2:0] {
    StWaitLock,
    StStabilize,
    StHold,
    StRun,
    StPllReset
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        loss_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              locked_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    loss_d  = lock_loss_count;
    unique case (state_q)
      StWaitLock: begin
`ifndef PLL_LOCK_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (locked_s) begin
          state_d = StStabilize;
          cnt_d   = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StPllReset;
          cnt_d   = '0;
`endif
        end
      end
      StStabilize: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(RESET_HOLD_CYCLES - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = StWaitLock;
          loss_d  = (lock_loss_count == 8'hFF) ? lock_loss_count : lock_loss_count + 8'd1;
        end
      end
      StPllReset: begin
        // Lock is ignored here; the PLL is being reset on purpose.
        if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StWaitLock;
      cnt_q           <= '0;
      rst_out         <= 1'b1;
      ready           <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rst_out         <= (state_d != StRun);
      ready           <= (state_d == StRun);
      lock_loss_count <= loss_d;
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pll_rst <= 1'b0;
    end else begin
      pll_rst <= (state_d == StPllReset);
    end
  end
`else
  assign pll_rst = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Bench: directed and randomized lock/loss traffic checked against a run-length model of the
// synchronized lock; a second instance exercises the lock timeout (PLL_LOCK_TIMEOUT_EN builds).
module tb_pll_lock_reset_sequencer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned LSC  = 4;
  localparam int unsigned RHC  = 3;
  localparam int unsigned REL  = LSC + RHC + 1;  // consecutive synchronized-high cycles to run

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       rst_out, ready, pll_rst;
  logic [7:0] lock_loss_count;
  logic       no_lock;
  logic       to_rst_out, to_ready, to_pll_rst;
  logic [7:0] to_count;

  int checks = 0;
  int errors = 0;

  // Model state
  logic       hist[$];
  int         run_len;
  int         exp_cnt;
  int         to_edge;

  pll_lock_reset_sequencer #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES (RHC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .rst_out        (rst_out),
    .ready          (ready),
    .lock_loss_count(lock_loss_count),
    .pll_rst        (pll_rst)
  );

  pll_lock_reset_sequencer #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES (RHC),
    .TIMEOUT_CYCLES    (20),
    .PLL_RST_CYCLES    (8)
  ) dut_to (
    .clock          (clock),
    .reset          (reset),
    .pll_locked     (no_lock),
    .rst_out        (to_rst_out),
    .ready          (to_ready),
    .lock_loss_count(to_count),
    .pll_rst        (to_pll_rst)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_to_pll_rst(input int n);
`ifdef PLL_LOCK_TIMEOUT_EN
    return ((n % 28) >= 20);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    hist.delete();
    run_len = 0;
    exp_cnt = 0;
    to_edge = 0;
  endtask

  // Drive one input value, let one edge sample it, update the model and compare.
  task automatic step(input logic v);
    logic seen;
    logic exp_ready;
    pll_locked = v;
    @(posedge clock);
    #1;
    to_edge++;
    hist.push_back(v);
    seen = (hist.size() > SYNC) ? hist.pop_front() : 1'b0;
    if (!seen && run_len >= int'(REL)) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
    run_len   = seen ? run_len + 1 : 0;
    exp_ready = (run_len >= int'(REL));
    check("ready", ready, exp_ready);
    check("rst_out", rst_out, !exp_ready);
    check("lock_loss_count", lock_loss_count, exp_cnt[7:0]);
    check("pll_rst", pll_rst, 1'b0);
    check("to_rst_out", to_rst_out, 1'b1);
    check("to_pll_rst", to_pll_rst, exp_to_pll_rst(to_edge));
  endtask

  // Assert reset between edges, confirm the immediate effect, release away from an edge.
  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    check("rst_async_rst_out", rst_out, 1'b1);
    check("rst_async_ready", ready, 1'b0);
    check("rst_async_count", lock_loss_count, 8'd0);
    check("rst_async_pll_rst", to_pll_rst, 1'b0);
    @(posedge clock);
    #2 reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b0;
    no_lock    = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check("reset_rst_out", rst_out, 1'b1);
    check("reset_ready", ready, 1'b0);
    check("reset_count", lock_loss_count, 8'd0);
    check("reset_pll_rst", pll_rst, 1'b0);
    reset = 1'b0;

    // Release: rst_out high through edge 9, released at edge 10.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      check("release_rst_out", rst_out, (i < 10) ? 1'b1 : 1'b0);
    end
    check("release_count", lock_loss_count, 8'd0);

    // Loss in RUN, then relock.
    for (int i = 1; i <= 3; i++) begin
      step(1'b0);
      check("loss_rst_out", rst_out, (i >= 3) ? 1'b1 : 1'b0);
    end
    check("loss_count", lock_loss_count, 8'd1);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      check("relock_ready", ready, (i == 10) ? 1'b1 : 1'b0);
    end

    // Drop during STABILIZE is not a loss event.
    do_reset();
    repeat (3) step(1'b1);
    repeat (5) step(1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      check("stab_drop_rst_out", rst_out, (i < 10) ? 1'b1 : 1'b0);
    end
    check("stab_drop_count", lock_loss_count, 8'd0);

    // Randomized lock/unlock traffic.
    for (int seg = 0; seg < 60; seg++) begin
      repeat ($urandom_range(1, 15)) step(1'b1);
      repeat ($urandom_range(1, 6)) step(1'b0);
    end

    // Saturation: 260 full release/loss cycles.
    do_reset();
    for (int k = 0; k < 260; k++) begin
      repeat ($urandom_range(10, 14)) step(1'b1);
      repeat ($urandom_range(3, 5)) step(1'b0);
    end
    check("sat_count", lock_loss_count, 8'd255);
    repeat (12) step(1'b1);
    repeat (4) step(1'b0);
    check("sat_hold_count", lock_loss_count, 8'd255);

    // Async reset mid-HOLD: 8 high edges lands in HOLD with a saturated count.
    repeat (8) step(1'b1);
    check("hold_rst_out", rst_out, 1'b1);
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      check("post_reset_release", ready, (i == 10) ? 1'b1 : 1'b0);
    end

    // Async reset in RUN drops ready without an edge.
    do_reset();

    // Long unlocked stretch covers several timeout periods of the second instance.
    repeat (90) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
